sw_alloc_output_arbiter: RTL
============================

Name: sw_alloc_output_arbiter

Overview:
Second (output-port) stage of the separable switch allocator; one instance per output port. It takes the one-hot candidate_port bits produced by the PORT_SEL_WIDTH first-stage (input-port) arbiters that can reach this output. It round-robin arbitrates among them, gated by per-output-VC credit availability, and returns a same-cycle grant that drives the first-stage port_granted inputs. It also owns the downstream credit counters and a registered crossbar-select / flit-valid for the switch-traversal stage.

Parameters:
VC_NUM_PER_PORT, 4, VCs per port (downstream VC count).
PORT_NUM, 5, router ports.
PORT_SEL_WIDTH, PORT_NUM-1, number of requesters (no U-turn).
CREDIT_NUM, 4, downstream buffer depth per VC (flits).
CREDIT_WIDTH, log2(CREDIT_NUM+1), credit counter width.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
requests  input  PORT_SEL_WIDTH  bit i = input port i's candidate targets this output.
req_out_vc  input  PORT_SEL_WIDTH*VC_NUM_PER_PORT  one-hot downstream VC per requester; slice i = [(i+1)*VC_NUM_PER_PORT-1 : i*VC_NUM_PER_PORT].
credit_in  input  VC_NUM_PER_PORT  one credit returned per set bit this cycle.
port_granted  output  PORT_SEL_WIDTH  combinational one-hot grant (or zero).
any_granted  output  1  OR of port_granted.
vc_has_credit  output  VC_NUM_PER_PORT  credit_cnt[v] != 0, from registered counters.
xbar_sel  output  PORT_SEL_WIDTH  registered port_granted.
xbar_vc  output  VC_NUM_PER_PORT  registered winner's req_out_vc.
flit_valid  output  1  registered any_granted.
credit_err  output  1  sticky credit-overflow flag.

Behaviour:
- Eligibility: elig[i] = requests[i] & |(req_out_vc slice i & vc_has_credit). An all-zero VC slice makes the requester ineligible. A multi-hot slice with requests[i]=1 is illegal; the bench asserts on it and RTL behaviour is undefined.
- Arbitration: a one-hot priority register prio (reset = 1 in bit 0). The grant goes to the first elig bit at or above prio, wrapping from MSB to bit 0. Purely combinational from inputs and registers; zero latency.
- Priority update: when any_granted=1, prio <= grant rotated left by 1 (bit PORT_SEL_WIDTH-1 wraps to bit 0). Otherwise prio holds.
- Credit counters credit_cnt[v], reset = CREDIT_NUM. The decrement dec[v] = any_granted & winner's req_out_vc[v].
  - dec only: cnt-1.
  - credit_in only: cnt+1.
  - Both in the same cycle: unchanged.
  - Neither: hold.
- Underflow cannot occur, because eligibility requires cnt != 0.
- Overflow: credit_in[v]=1 with no dec while cnt = CREDIT_NUM. The counter holds at CREDIT_NUM and credit_err <= 1. credit_err stays set until reset.
- Registered outputs: xbar_sel, xbar_vc and flit_valid update every cycle from this cycle's grant (1-cycle latency). When there is no grant they become 0. All reset to 0.
- Reset mid-operation: all registers return to reset values asynchronously. Combinational port_granted then reflects reset prio and full credits.
- CREDIT_NUM=1: a grant to VC v blocks all further grants to v until credit_in[v] arrives. A credit returned in the grant cycle allows back-to-back grants.

Test Plan:
- Post-reset, requests=4'b1111, all req_out_vc=VC0, no credits returned -> grants in order 0001, 0010, 0100, 1000. Cycle 5: no grant, vc_has_credit[0]=0, cnt[0]=0. xbar_sel lags port_granted by 1 cycle.
- Credit gating: requests=4'b0011. Requester0 targets VC1 with cnt=0; requester1 targets VC2 with cnt=4 -> port_granted=0010 even though prio=0001. prio becomes 0100.
- Simultaneous dec and credit_in on VC3 at cnt=2 -> cnt stays 2. A credit_in alone on the next cycle gives 3.
- Overflow: credit_in[0]=1 at cnt=4 with no grant -> cnt stays 4, credit_err=1 and held. Asserting reset clears it to 0 and restores all counts to 4.
- Wrap fairness: prio=1000, requests=4'b1001, both eligible -> grant 1000, next prio 0001. Next cycle grant 0001.
- Async reset asserted mid-cycle during active grants -> xbar_sel, xbar_vc and flit_valid go to 0 immediately without waiting for a clock edge. prio becomes 0001.

Source files
------------

// File: rtl/sw_alloc_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sw_alloc_output_arbiter
//  Description : Output-port stage of the separable switch allocator. It
//                round-robin arbitrates the first-stage candidates, gated by
//                downstream VC credits, and owns the credit counters and the
//                registered crossbar select.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_alloc_output_arbiter #(
    parameter int VC_NUM_PER_PORT = 4,
    parameter int PORT_NUM        = 5,
    parameter int PORT_SEL_WIDTH  = PORT_NUM - 1,
    parameter int CREDIT_NUM      = 4,
    parameter int CREDIT_WIDTH    = $clog2(CREDIT_NUM + 1)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [PORT_SEL_WIDTH-1:0]                  requests,
    input  logic [PORT_SEL_WIDTH*VC_NUM_PER_PORT-1:0]  req_out_vc,
    input  logic [VC_NUM_PER_PORT-1:0]                 credit_in,
    output logic [PORT_SEL_WIDTH-1:0]                  port_granted,
    output logic                                       any_granted,
    output logic [VC_NUM_PER_PORT-1:0]                 vc_has_credit,
    output logic [PORT_SEL_WIDTH-1:0]                  xbar_sel,
    output logic [VC_NUM_PER_PORT-1:0]                 xbar_vc,
    output logic                                       flit_valid,
    output logic                                       credit_err
);

    localparam logic [CREDIT_WIDTH-1:0] C_CREDIT_MAX = CREDIT_WIDTH'(CREDIT_NUM);
    localparam logic [CREDIT_WIDTH-1:0] C_CREDIT_ONE = CREDIT_WIDTH'(1);

    logic [PORT_SEL_WIDTH-1:0]   r_prio;
    logic [PORT_SEL_WIDTH-1:0]   w_elig;
    logic [PORT_SEL_WIDTH-1:0]   w_grant;
    logic [2*PORT_SEL_WIDTH-1:0] w_elig_dbl;
    logic [2*PORT_SEL_WIDTH-1:0] w_grant_dbl;
    logic                        w_any;
    logic [VC_NUM_PER_PORT-1:0]  w_win_vc;
    logic [VC_NUM_PER_PORT-1:0]  w_dec;
    logic [VC_NUM_PER_PORT-1:0]  w_ovf;
    logic [VC_NUM_PER_PORT-1:0]  w_has_credit;

    logic [PORT_SEL_WIDTH-1:0]   r_xbar_sel;
    logic [VC_NUM_PER_PORT-1:0]  r_xbar_vc;
    logic                        r_flit_valid;
    logic                        r_credit_err;

    // A requester is eligible only if its chosen downstream VC has a credit.
    generate
        for (genvar i = 0; i < PORT_SEL_WIDTH; i++) begin : g_elig
            assign w_elig[i] = requests[i] &
                               (|(req_out_vc[i*VC_NUM_PER_PORT +: VC_NUM_PER_PORT] & w_has_credit));
        end
    endgenerate

    // Doubled-vector trick: the subtraction clears everything below prio, so
    // the lowest surviving set bit is the first eligible requester at or
    // above prio; folding the halves handles the wrap back to bit 0.
    assign w_elig_dbl  = {w_elig, w_elig};
    assign w_grant_dbl = w_elig_dbl & ~(w_elig_dbl - {{PORT_SEL_WIDTH{1'b0}}, r_prio});
    assign w_grant     = w_grant_dbl[PORT_SEL_WIDTH-1:0] |
                         w_grant_dbl[2*PORT_SEL_WIDTH-1:PORT_SEL_WIDTH];
    assign w_any       = |w_grant;

    always_comb begin
        w_win_vc = '0;
        for (int i = 0; i < PORT_SEL_WIDTH; i++) begin
            if (w_grant[i]) begin
                w_win_vc = w_win_vc | req_out_vc[i*VC_NUM_PER_PORT +: VC_NUM_PER_PORT];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= {{(PORT_SEL_WIDTH-1){1'b0}}, 1'b1};
        end else if (w_any) begin
            r_prio <= {w_grant[PORT_SEL_WIDTH-2:0], w_grant[PORT_SEL_WIDTH-1]};
        end
    end

    // Per-VC downstream credit counters; a simultaneous send and return cancel.
    generate
        for (genvar v = 0; v < VC_NUM_PER_PORT; v++) begin : g_vc
            logic [CREDIT_WIDTH-1:0] r_credit_cnt;

            assign w_dec[v]        = w_any & w_win_vc[v];
            assign w_ovf[v]        = credit_in[v] & ~w_dec[v] & (r_credit_cnt == C_CREDIT_MAX);
            assign w_has_credit[v] = (r_credit_cnt != '0);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_credit_cnt <= C_CREDIT_MAX;
                end else if (w_dec[v] && !credit_in[v]) begin
                    r_credit_cnt <= r_credit_cnt - C_CREDIT_ONE;
                end else if (credit_in[v] && !w_dec[v] && (r_credit_cnt != C_CREDIT_MAX)) begin
                    r_credit_cnt <= r_credit_cnt + C_CREDIT_ONE;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit_err <= 1'b0;
        end else if (|w_ovf) begin
            r_credit_err <= 1'b1;
        end
    end

    // Switch-traversal stage select; w_win_vc is already zero with no grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xbar_sel   <= '0;
            r_xbar_vc    <= '0;
            r_flit_valid <= 1'b0;
        end else begin
            r_xbar_sel   <= w_grant;
            r_xbar_vc    <= w_win_vc;
            r_flit_valid <= w_any;
        end
    end

    assign port_granted  = w_grant;
    assign any_granted   = w_any;
    assign vc_has_credit = w_has_credit;
    assign xbar_sel      = r_xbar_sel;
    assign xbar_vc       = r_xbar_vc;
    assign flit_valid    = r_flit_valid;
    assign credit_err    = r_credit_err;

endmodule
`default_nettype wire
